// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared direction/mode encodings and next-state select for the up/down counter
package counter_pkg;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_LOAD,
        SEL_INC,
        SEL_DEC,
        SEL_WRAP_LO,
        SEL_WRAP_HI,
        SEL_SAT
    } next_sel_e;

endpackage

// File: rtl/updown_next_calc.sv
// rtl/updown_next_calc.sv - combinational step value, boundary events and terminal count
module updown_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] limit,
    input  logic             up_down,
    input  logic             sat_mode,
    output next_sel_e        step_sel,
    output logic [WIDTH-1:0] step_val,
    output logic             up_evt,
    output logic             dn_evt,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        step_sel = SEL_INC;
        step_val = count;
        up_evt   = 1'b0;
        dn_evt   = 1'b0;
        if (up_down == DIR_UP) begin
            if (count < limit) begin
                step_sel = SEL_INC;
                step_val = count + ONE;
            end else begin
                // A count above limit (after a load) also takes the boundary path.
                up_evt = 1'b1;
                if (sat_mode == MODE_SAT) begin
                    step_sel = SEL_SAT;
                    step_val = limit;
                end else begin
                    step_sel = SEL_WRAP_LO;
                    step_val = '0;
                end
            end
        end else begin
            if (count != '0) begin
                step_sel = SEL_DEC;
                step_val = count - ONE;
            end else begin
                dn_evt = 1'b1;
                if (sat_mode == MODE_SAT) begin
                    step_sel = SEL_SAT;
                    step_val = '0;
                end else begin
                    step_sel = SEL_WRAP_HI;
                    step_val = limit;
                end
            end
        end
    end

    assign tc = (up_down == DIR_UP) ? (count >= limit) : (count == '0);

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, wrap/saturate and sticky flags
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    next_sel_e        step_sel, sel;
    logic [WIDTH-1:0] step_val;
    logic             up_evt, dn_evt, step_en;

    updown_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .count    (count_q),
        .limit    (limit),
        .up_down  (up_down),
        .sat_mode (sat_mode),
        .step_sel (step_sel),
        .step_val (step_val),
        .up_evt   (up_evt),
        .dn_evt   (dn_evt),
        .tc       (tc)
    );

    assign step_en = en && !load;

    always_comb begin
        sel     = SEL_HOLD;
        count_d = count_q;
        if (load) begin
            sel = SEL_LOAD;
        end else if (en) begin
            sel = step_sel;
        end
        case (sel)
            SEL_HOLD: count_d = count_q;
            SEL_LOAD: count_d = load_val;
            default:  count_d = step_val;
        endcase
    end

    // A boundary event on the clearing edge keeps its own flag set.
    always_comb begin
        ovf_d = (step_en && up_evt) || (ovf_q && !clr_flags);
        udf_d = (step_en && dn_evt) || (udf_q && !clr_flags);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RESET_COUNT;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: doc/updown_counter_param.md
Name: updown_counter_param

Overview:
- Parametrised successor to the team's fixed 4-bit up/down counter.
- Adds runtime-programmable terminal value, wrap/saturate mode, count enable, parallel load, a terminal-count indicator, and sticky overflow/underflow flags with clear.
- Used as a general event/timer/index counter in datapath and control blocks; all state is in one clock domain.

Parameters:
- WIDTH, 4, count width in bits (legal range 2..32).
- RESET_VAL, 0, value `count` takes on reset (must be <= 2^WIDTH-1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; `count` holds when low (load still honoured).
- up_down  input  1  direction: 1 = increment, 0 = decrement (same sense as the 4-bit counter).
- sat_mode  input  1  0 = wrap at boundaries, 1 = saturate at boundaries.
- limit  input  WIDTH  upper terminal value; counting range is 0..limit.
- load  input  1  parallel-load strobe.
- load_val  input  WIDTH  value written on load.
- clr_flags  input  1  clears the sticky `ovf` and `udf` flags.
- count  output  WIDTH  registered count value.
- tc  output  1  terminal count, combinational: (up_down && count>=limit) || (!up_down && count==0).
- ovf  output  1  sticky: an up-boundary event has occurred.
- udf  output  1  sticky: a down-boundary event has occurred.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: count=RESET_VAL, ovf=0, udf=0. `tc` follows from count. Reset overrides every other input in the same cycle, including mid-count and mid-load.
- Priority per edge: reset > load > en > hold.
- Load:
  - count <= load_val verbatim, with no clamping to `limit`.
  - Load ignores `en`, `up_down` and `sat_mode`.
  - Load never sets `ovf` or `udf`.
- Enabled count, up (en=1, up_down=1):
  - count < limit: count+1.
  - count >= limit: up-boundary event. Wrap mode gives 0; saturate mode gives `limit` (also pulls an out-of-range count back to `limit`).
- Enabled count, down (en=1, up_down=0):
  - count > 0: count-1, including when count > limit.
  - count == 0: down-boundary event. Wrap mode gives `limit`; saturate mode holds 0.
- limit == 0:
  - Up always wraps or saturates to 0.
  - Down at 0 also yields 0 and still flags `udf`.
- Arithmetic: all comparisons are unsigned at WIDTH bits. The next-state value never exceeds 2^WIDTH-1. There is no carry-out port; overflow is reported only through the boundary event.
- Latency:
  - `count` updates 1 cycle after the qualifying edge.
  - `tc` reflects the current `count`, `limit` and `up_down` with zero latency.
  - `ovf`/`udf` assert on the same edge that applies the boundary transition.
- Sticky flags:
  - An up-boundary event sets `ovf`; a down-boundary event sets `udf`.
  - `clr_flags` clears both flags on the next edge.
  - If a boundary event and `clr_flags` occur in the same cycle, set wins for the flag being set; the other flag clears.
- Runtime changes:
  - `limit` may change at any cycle and takes effect on the next edge.
  - `sat_mode` and `up_down` take effect on the next enabled edge; there is no pipeline to drain.

Decomposition:
- Shared package `counter_pkg`:
  - `DIR_DOWN` = 0, `DIR_UP` = 1.
  - `MODE_WRAP` = 0, `MODE_SAT` = 1.
  - A typedef for the next-state select: HOLD, LOAD, INC, DEC, WRAP_LO, WRAP_HI, SAT.
- One natural sub-module, `updown_next_calc`:
  - Purely combinational.
  - Computes next count, boundary-event flags and `tc` from count, limit, direction and mode.
  - The top level holds the registers and priority logic.

Test Plan:
- Reset and priority (WIDTH=4, RESET_VAL=5): assert reset together with load=1 and load_val=9 -> count=5, ovf=0, udf=0 next edge.
- Wrap up: limit=9, wrap mode, start count=8, up, en, 3 cycles -> count 9, 0, 1; tc=1 while count=9; ovf sets on the 9->0 edge.
- Saturate down: limit=9, sat mode, count=1, down, 3 cycles -> count 0, 0, 0; udf=1; tc=1 at count 0.
- Load above limit: limit=6, load_val=12, then up in wrap mode -> count 12, then 0 with ovf=1. Repeat in sat mode -> count 6.
- Enable gating and full-range wrap: limit=15, count=15, en=0 for 2 cycles -> count holds 15. Then en=1, up -> 0 and ovf=1. Then down -> 15 and udf=1.
- Flag clear race: with ovf=1 and udf=1, assert clr_flags in the same cycle as an up-boundary event -> ovf=1, udf=0. Clear again with no event -> both 0.
